// File: rtl/format_sweep_test_if.sv
// rtl/format_sweep_test_if.sv - start/stall control and status bundle for the format sweep block
interface format_sweep_test_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             stall;
  logic [WIDTH-1:0] counter;
  logic [WIDTH-1:0] data;
  logic [2:0]       step;
  logic             busy;
  logic             done;

  modport master (
    output start, stall,
    input  counter, data, step, busy, done
  );

  modport slave (
    input  start, stall,
    output counter, data, step, busy, done
  );
endinterface

// File: rtl/format_sweep_test.sv
// rtl/format_sweep_test.sv - start-triggered, stallable sweep printing one format per step
module format_sweep_test #(
  parameter int               WIDTH     = 8,
  parameter int               NUM_STEPS = 8,
  parameter logic [WIDTH-1:0] INIT_DATA = WIDTH'('hAA),
  parameter logic [WIDTH-1:0] TOGGLE    = WIDTH'('h55)
) (
  input logic                clk,
  input logic                rst,
  format_sweep_test_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [2:0] LAST = 3'(NUM_STEPS - 1);

  state_t           state;
  logic [WIDTH-1:0] counter;
  logic [WIDTH-1:0] data;
  logic [2:0]       step;
  logic             busy;
  logic             done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      counter <= '0;
      data    <= INIT_DATA;
      step    <= 3'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // counter deliberately survives restarts so chained sweeps keep counting
          if (bus.start) begin
            state <= RUN;
            step  <= 3'd0;
            data  <= INIT_DATA;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        RUN: begin
          if (!bus.stall) begin
            counter <= counter + WIDTH'(1);
            data    <= data ^ TOGGLE;
            if (step == LAST) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              step <= step + 3'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.counter = counter;
  assign bus.data    = data;
  assign bus.step    = step;
  assign bus.busy    = busy;
  assign bus.done    = done;

`ifndef SYNTHESIS
  // Runs on the same edge as the state update, so it reports pre-edge values
  always @(posedge clk) begin
    if (!rst && state == RUN && !bus.stall) begin
      if (step == LAST) begin
        $display("Step %0d: All tests passed!", step);
      end else begin
        case (step)
          3'd0: $display("Step 0: dec counter=%d data=%d", counter, data);
          3'd1: $display("Step 1: hex counter=%h data=%h", counter, data);
          3'd2: $display("Step 2: bin counter=%b data=%b", counter, data);
          3'd3: $display("Step 3: oct counter=%o data=%o", counter, data);
          3'd4: $display("Step 4: nopad counter=%0d data=%0h", counter, data);
          3'd5: $display("Step 5: signed data=%d", $signed(data));
          3'd6: $display("Step 6: multi %d %h %b %0d", counter, counter, data, data);
          default: ;
        endcase
      end
    end
  end
`endif
endmodule
